// File: rtl/sp_ram_burst_reader_if.sv
// Bundle of the burst reader's command, stream and RAM port signals.
//   cmd_*   : burst command (valid/ready handshake, byte address, word count)
//   data_*  : read stream toward the consumer (valid/ready, last marker)
//   done_o  : one-cycle burst-complete pulse
//   ram_*   : single-port RAM initiator port (1-cycle read latency)
// Modports: master = burst reader side, slave = surrounding logic / RAM side.
interface sp_ram_burst_reader_if #(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 16
);
    logic                    cmd_valid_i;
    logic                    cmd_ready_o;
    logic [ADDR_WIDTH-1:0]   cmd_addr_i;
    logic [LEN_WIDTH-1:0]    cmd_len_i;
    logic                    data_valid_o;
    logic                    data_ready_i;
    logic [DATA_WIDTH-1:0]   data_o;
    logic                    data_last_o;
    logic                    done_o;
    logic                    ram_en_o;
    logic [ADDR_WIDTH-1:0]   ram_addr_o;
    logic                    ram_we_o;
    logic [DATA_WIDTH/8-1:0] ram_be_o;
    logic [DATA_WIDTH-1:0]   ram_wdata_o;
    logic [DATA_WIDTH-1:0]   ram_rdata_i;

    modport master (
        input  cmd_valid_i, cmd_addr_i, cmd_len_i, data_ready_i, ram_rdata_i,
        output cmd_ready_o, data_valid_o, data_o, data_last_o, done_o,
               ram_en_o, ram_addr_o, ram_we_o, ram_be_o, ram_wdata_o
    );

    modport slave (
        output cmd_valid_i, cmd_addr_i, cmd_len_i, data_ready_i, ram_rdata_i,
        input  cmd_ready_o, data_valid_o, data_o, data_last_o, done_o,
               ram_en_o, ram_addr_o, ram_we_o, ram_be_o, ram_wdata_o
    );
endinterface

// File: rtl/sp_ram_burst_reader.sv
// Burst reader: accepts (start byte address, word count) and streams that many
// consecutive RAM words out on a valid/ready stream with a last marker.
// Ports:
//   clk   : clock
//   rst_i : synchronous active-high reset (aborts any burst, no done pulse)
//   bus   : sp_ram_burst_reader_if.master (command, stream, done, RAM port)
module sp_ram_burst_reader #(
    parameter int RAM_SIZE   = 32768,
    parameter int ADDR_WIDTH = $clog2(RAM_SIZE),
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_i,
    sp_ram_burst_reader_if.master bus
);
    localparam int WORD_AW = ADDR_WIDTH - 2;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t                 state_q, state_d;
    logic [WORD_AW-1:0]     ptr_q;
    logic [LEN_WIDTH-1:0]   remaining_q;
    logic                   inflight_q;
    logic                   inflight_last_q;

    logic [DATA_WIDTH-1:0]  fifo_data [2];
    logic                   fifo_last [2];
    logic                   rd_idx_q, wr_idx_q;
    logic [1:0]             count_q;

    logic                   accept, issue, pop, fifo_push, fifo_pop, head_valid;
    logic [1:0]             occupancy;

    // The word arriving from the RAM is presented directly when the FIFO is
    // empty, so the stream sees data one cycle after ram_en_o; it only enters
    // the FIFO if it is not consumed in that same cycle.
    assign head_valid = (count_q != 2'd0) || inflight_q;
    assign pop        = head_valid && bus.data_ready_i;
    assign fifo_pop   = pop && (count_q != 2'd0);
    assign fifo_push  = inflight_q && !(pop && (count_q == 2'd0));
    assign occupancy  = count_q + 2'(inflight_q) - 2'(pop);
    assign accept     = (state_q == S_IDLE) && bus.cmd_valid_i;
    assign issue      = (state_q == S_BUSY) && (remaining_q != '0) && (occupancy < 2'd2);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (accept) state_d = (bus.cmd_len_i == '0) ? S_DONE : S_BUSY;
            S_BUSY: if ((remaining_q == '0) && (occupancy == 2'd0)) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            state_q         <= S_IDLE;
            ptr_q           <= '0;
            remaining_q     <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            rd_idx_q        <= 1'b0;
            wr_idx_q        <= 1'b0;
            count_q         <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                ptr_q       <= bus.cmd_addr_i[ADDR_WIDTH-1:2];
                remaining_q <= bus.cmd_len_i;
            end else if (issue) begin
                ptr_q       <= ptr_q + WORD_AW'(1);
                remaining_q <= remaining_q - LEN_WIDTH'(1);
            end
            inflight_q      <= issue;
            inflight_last_q <= issue && (remaining_q == LEN_WIDTH'(1));
            if (fifo_push) wr_idx_q <= ~wr_idx_q;
            if (fifo_pop)  rd_idx_q <= ~rd_idx_q;
            count_q <= count_q + 2'(fifo_push) - 2'(fifo_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_push) begin
            fifo_data[wr_idx_q] <= bus.ram_rdata_i;
            fifo_last[wr_idx_q] <= inflight_last_q;
        end
    end

    assign bus.cmd_ready_o  = (state_q == S_IDLE);
    assign bus.done_o       = (state_q == S_DONE);
    assign bus.data_valid_o = head_valid;
    assign bus.data_o       = (count_q != 2'd0) ? fifo_data[rd_idx_q] : bus.ram_rdata_i;
    assign bus.data_last_o  = (count_q != 2'd0) ? fifo_last[rd_idx_q] : (inflight_q && inflight_last_q);
    assign bus.ram_en_o     = issue;
    assign bus.ram_addr_o   = {ptr_q, 2'b00};
    assign bus.ram_we_o     = 1'b0;
    assign bus.ram_be_o     = '1;
    assign bus.ram_wdata_o  = '0;
endmodule

// File: tb/tb_sp_ram_burst_reader.sv
// Scoreboard bench for sp_ram_burst_reader: expected RAM addresses and stream
// words are queued when a command is issued; a negedge monitor pops and
// compares them whenever the DUT issues a read or delivers a word.
module tb_sp_ram_burst_reader;
    localparam int RAM_SIZE = 32768;
    localparam int AW = 15;
    localparam int DW = 32;
    localparam int LW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    int          exp_addr_q[$];
    logic [32:0] exp_word_q[$];

    int ready_mode = 0;   // 0: always ready, 1: toggle, 2: never ready
    int outstanding = 0;
    int n_en, n_pop, n_done, first_en, last_en, first_pop, last_pop;

    sp_ram_burst_reader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus ();

    sp_ram_burst_reader #(
        .RAM_SIZE(RAM_SIZE), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)
    ) dut (
        .clk   (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] ram_val(input int a);
        return 32'hD00D0000 | (a & 32'hFFFF);
    endfunction

    // RAM model: 1-cycle read latency
    always @(posedge clk) if (bus.ram_en_o) bus.ram_rdata_i <= ram_val(int'(bus.ram_addr_o));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial begin
        bus.data_ready_i = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: bus.data_ready_i = 1'b1;
                1: bus.data_ready_i = ~bus.data_ready_i;
                default: bus.data_ready_i = 1'b0;
            endcase
        end
    end

    // Monitor / scoreboard
    always @(negedge clk) begin
        logic        p;
        logic [32:0] w;
        int          a;
        if (!rst) begin
            p = bus.data_valid_o && bus.data_ready_i;
            if (bus.ram_en_o) begin
                n_en++;
                if (first_en < 0) first_en = cyc;
                last_en = cyc;
                if (exp_addr_q.size() == 0) check("unexpected_ram_en", 64'(bus.ram_en_o), 64'd0);
                else begin
                    a = exp_addr_q.pop_front();
                    check("ram_addr", 64'(bus.ram_addr_o), 64'(a));
                end
                check("issue_limit", 64'((outstanding - int'(p)) < 2), 64'd1);
            end
            if (p) begin
                n_pop++;
                if (first_pop < 0) first_pop = cyc;
                last_pop = cyc;
                if (exp_word_q.size() == 0) check("unexpected_pop", 64'(bus.data_valid_o), 64'd0);
                else begin
                    w = exp_word_q.pop_front();
                    check("data", 64'(bus.data_o), 64'(w[31:0]));
                    check("last", 64'(bus.data_last_o), 64'(w[32]));
                end
            end
            if (bus.done_o) n_done++;
            outstanding = outstanding + int'(bus.ram_en_o) - int'(p);
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd_ready"}, 64'(bus.cmd_ready_o), 64'd1);
        check({tag, "_data_valid"}, 64'(bus.data_valid_o), 64'd0);
        check({tag, "_data_last"}, 64'(bus.data_last_o), 64'd0);
        check({tag, "_done"}, 64'(bus.done_o), 64'd0);
        check({tag, "_ram_en"}, 64'(bus.ram_en_o), 64'd0);
        check({tag, "_ram_addr"}, 64'(bus.ram_addr_o), 64'd0);
    endtask

    task automatic clear_trackers();
        n_en = 0; n_pop = 0; n_done = 0;
        first_en = -1; last_en = -1; first_pop = -1; last_pop = -1;
    endtask

    task automatic send_cmd(input int addr, input int len, output int hs);
        int k;
        for (int i = 0; i < len; i++) begin
            int w;
            w = ((addr >> 2) + i) % (RAM_SIZE / 4);
            exp_addr_q.push_back(w * 4);
            exp_word_q.push_back({(i == len - 1), ram_val(w * 4)});
        end
        @(posedge clk); #1;
        bus.cmd_valid_i = 1'b1;
        bus.cmd_addr_i  = AW'(addr);
        bus.cmd_len_i   = LW'(len);
        k = 0;
        @(negedge clk);
        while (!bus.cmd_ready_o && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("cmd_accept", 64'(bus.cmd_ready_o), 64'd1);
        hs = cyc;
        @(posedge clk); #1;
        bus.cmd_valid_i = 1'b0;
    endtask

    task automatic run_burst(input string tag, input int addr, input int len, input int mode);
        int hs, done_at, k;
        ready_mode = mode;
        clear_trackers();
        send_cmd(addr, len, hs);
        done_at = -1;
        k = 0;
        while (done_at < 0 && k < 300) begin
            @(negedge clk);
            if (bus.done_o) done_at = cyc;
            k++;
        end
        check({tag, "_done_seen"}, 64'(done_at >= 0), 64'd1);
        check({tag, "_words_left"}, 64'(exp_word_q.size()), 64'd0);
        check({tag, "_pops"}, 64'(n_pop), 64'(len));
        check({tag, "_reads"}, 64'(n_en), 64'(len));
        if (len == 0) begin
            check({tag, "_done_cycle"}, 64'(done_at), 64'(hs + 1));
        end else begin
            check({tag, "_done_after_last"}, 64'(done_at), 64'(last_pop + 1));
            if (mode == 0) begin
                check({tag, "_first_en"}, 64'(first_en), 64'(hs + 1));
                check({tag, "_last_en"}, 64'(last_en), 64'(hs + len));
                check({tag, "_first_pop"}, 64'(first_pop), 64'(hs + 2));
                check({tag, "_last_pop"}, 64'(last_pop), 64'(hs + len + 1));
            end
        end
        @(negedge clk);
        check({tag, "_done_pulse"}, 64'(bus.done_o), 64'd0);
        check({tag, "_done_count"}, 64'(n_done), 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int hs;
        bus.cmd_valid_i = 1'b0;
        bus.cmd_addr_i  = '0;
        bus.cmd_len_i   = '0;
        clear_trackers();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset");
        check("ram_we", 64'(bus.ram_we_o), 64'd0);
        check("ram_be", 64'(bus.ram_be_o), 64'hF);
        check("ram_wdata", 64'(bus.ram_wdata_o), 64'd0);

        run_burst("t1_basic", 32'h100, 4, 0);
        run_burst("t2_toggle", 32'h040, 8, 1);
        run_burst("t3_wrap", 32'h7FF8, 4, 0);
        run_burst("t4_len0", 32'h010, 0, 0);
        run_burst("t5_unaligned", 32'h203, 1, 0);

        // Reset mid-burst with the consumer stalled
        ready_mode = 2;
        clear_trackers();
        send_cmd(32'h300, 16, hs);
        repeat (6) @(negedge clk);
        check("t6_stalled_valid", 64'(bus.data_valid_o), 64'd1);
        check("t6_stalled_no_en", 64'(bus.ram_en_o), 64'd0);
        check("t6_reads_before_rst", 64'(n_en), 64'd2);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        exp_addr_q.delete();
        exp_word_q.delete();
        outstanding = 0;
        @(negedge clk);
        check_reset_outputs("t6_after_rst");
        ready_mode = 0;
        repeat (6) @(negedge clk);
        check("t6_no_done", 64'(n_done), 64'd0);
        check("t6_idle_valid", 64'(bus.data_valid_o), 64'd0);
        run_burst("t6_resume", 32'h080, 3, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
